lsu: RTL and testbench

Load/store unit between the PYGMY-V32I execute stage and the on-chip data SRAM. It accepts one RV32I load or store at a time and checks alignment, address range and size encoding. It drives the SRAM's req/ce/gnt handshake with stable address and size, and returns a sign- or zero-extended load result or an error cause to the core.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_if.sv | 37 +++
 rtl/lsu_load_ext.sv | 23 ++
 rtl/lsu.sv | 152 +++++++++++++++
 tb/tb_lsu.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the PYGMY-V32I load/store unit and its SRAM port:
// funct3 width codes, SRAM size encodings, error causes and FSM states.
package lsu_pkg;

    // RV32I load/store width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // SRAM access size; 2'b11 is reserved and never driven
    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_LD_MISAL = 3'd1,
        CAUSE_ST_MISAL = 3'd2,
        CAUSE_LD_RANGE = 3'd3,
        CAUSE_ST_RANGE = 3'd4,
        CAUSE_TIMEOUT  = 3'd5,
        CAUSE_SIZE     = 3'd6
    } cause_e;

    // One-hot so each state decodes from a single flop
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_REQ   = 4'b0010,
        ST_RESP  = 4'b0100,
        ST_FAULT = 4'b1000
    } state_e;

    // Stores only have the three signed widths; loads add the unsigned pair
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Low two funct3 bits carry the access size
    function automatic logic [1:0] f3_hb(input logic [1:0] sz);
        case (sz)
            2'b00:   return HB_BYTE;
            2'b01:   return HB_HALF;
            default: return HB_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and SRAM req/gnt signals of the load/store unit.
interface lsu_if;
    // core side
    logic        valid_i;
    logic        ready_o;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [2:0]  cause_o;
    // SRAM side
    logic        mem_req_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [1:0]  mem_hb_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic [31:0] mem_rdata_i;

    // the LSU itself
    modport slave (
        input  valid_i, we_i, funct3_i, addr_i, wdata_i, mem_gnt_i, mem_rdata_i,
        output ready_o, done_o, rdata_o, err_o, cause_o,
               mem_req_o, mem_ce_o, mem_we_o, mem_hb_o, mem_addr_o, mem_wdata_o
    );

    // whoever drives the core requests and answers as the SRAM
    modport master (
        output valid_i, we_i, funct3_i, addr_i, wdata_i, mem_gnt_i, mem_rdata_i,
        input  ready_o, done_o, rdata_o, err_o, cause_o,
               mem_req_o, mem_ce_o, mem_we_o, mem_hb_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of right-justified read data by RV32I load width.
// Purely combinational so an uncached peripheral path can share it.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Pick the extension from the load width code
    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ext = {24'h0, raw[7:0]};
            F3_HU:   ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one RV32I load or store at a time between execute and the
// data SRAM. Checks size, alignment and window at accept, runs the SRAM
// req/gnt handshake with a bounded wait, and reports data or an error cause.
module lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = 32'h0000_2000,
    parameter int unsigned RAM_BYTES = 8192,
    parameter int unsigned TIMEOUT   = 15
) (
    input logic  clk_i,
    input logic  rst_ni,
    lsu_if.slave bus
);

    state_e      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] off_q;
    logic [31:0] wdata_q;
    logic [7:0]  wait_cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;
    cause_e      cause_q;

    logic        accept, in_req, timeout, misal, out_of_win;
    cause_e      chk_cause;
    logic [31:0] ext_data;
    logic [32:0] win_end;

    assign in_req  = (state_q == ST_REQ);
    assign accept  = bus.valid_i && (state_q == ST_IDLE);
    // Counter holds the number of grant-less REQ cycles already completed,
    // so the last allowed cycle is the one where it equals TIMEOUT-1.
    assign timeout = (wait_cnt_q == 8'(TIMEOUT - 1));
    // 33 bits so a window touching the top of the address space still works
    assign win_end = {1'b0, RAM_BASE} + 33'(RAM_BYTES);

    // Accept-time checks in priority order: size, alignment, window
    always_comb begin
        misal = ((bus.funct3_i[1:0] == 2'b10) && (bus.addr_i[1:0] != 2'b00)) ||
                ((bus.funct3_i[1:0] == 2'b01) && bus.addr_i[0]);
        out_of_win = (bus.addr_i < RAM_BASE) || ({1'b0, bus.addr_i} >= win_end);
        chk_cause = CAUSE_NONE;
        if (!f3_legal(bus.we_i, bus.funct3_i)) begin
            chk_cause = CAUSE_SIZE;
        end else if (misal) begin
            if (bus.we_i) chk_cause = CAUSE_ST_MISAL;
            else          chk_cause = CAUSE_LD_MISAL;
        end else if (out_of_win) begin
            if (bus.we_i) chk_cause = CAUSE_ST_RANGE;
            else          chk_cause = CAUSE_LD_RANGE;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state and all outputs; mem_* are gated to zero outside REQ
    always_comb begin
        state_d         = state_q;
        bus.ready_o     = 1'b0;
        bus.done_o      = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_ce_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_hb_o    = HB_BYTE;
        bus.mem_addr_o  = 32'h0;
        bus.mem_wdata_o = 32'h0;
        bus.err_o       = err_q;
        bus.cause_o     = cause_q;
        bus.rdata_o     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                bus.ready_o = 1'b1;
                if (accept) begin
                    if (chk_cause == CAUSE_NONE) state_d = ST_REQ;
                    else                         state_d = ST_FAULT;
                end
            end
            ST_REQ: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_ce_o    = 1'b1;
                bus.mem_we_o    = we_q;
                bus.mem_hb_o    = f3_hb(f3_q[1:0]);
                bus.mem_addr_o  = off_q;
                bus.mem_wdata_o = wdata_q;
                // grant beats timeout when both land in the same cycle
                if (bus.mem_gnt_i)  state_d = ST_RESP;
                else if (timeout)   state_d = ST_FAULT;
            end
            ST_RESP, ST_FAULT: begin
                bus.done_o = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request once; it stays frozen for the whole REQ phase
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 32'h0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= bus.we_i;
            f3_q    <= bus.funct3_i;
            off_q   <= bus.addr_i - RAM_BASE;
            wdata_q <= bus.wdata_i;
        end
    end

    // Count REQ cycles that passed without a grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                         wait_cnt_q <= 8'h0;
        else if (accept)                     wait_cnt_q <= 8'h0;
        else if (in_req && !bus.mem_gnt_i)   wait_cnt_q <= wait_cnt_q + 8'd1;
    end

    // Completion result, held until the next completion overwrites it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else if (accept && (chk_cause != CAUSE_NONE)) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            cause_q <= chk_cause;
        end else if (in_req && bus.mem_gnt_i) begin
            rdata_q <= we_q ? 32'h0 : ext_data;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else if (in_req && timeout) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
        end
    end

    lsu_load_ext u_load_ext (
        .funct3 (f3_q),
        .raw    (bus.mem_rdata_i),
        .ext    (ext_data)
    );

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: an SRAM model with programmable grant delay, a
// reference model that predicts latency/cause/data from the ISA rules, and
// one negedge compare process checking every cycle against the prediction.
module tb_lsu;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          BYTES = 8192;
    localparam int          TMO   = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus ();

    lsu #(.RAM_BASE(BASE), .RAM_BYTES(BYTES), .TIMEOUT(TMO)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // ---------------- SRAM model ----------------
    logic [7:0]  sram [BYTES];
    bit          inited = 1'b0;
    int          held;     // consecutive completed request cycles so far
    int          gnt_at = 3;  // grant on this cycle of a held request, 0 = never
    logic [12:0] ra;

    assign ra = bus.mem_addr_o[12:0];
    assign bus.mem_gnt_i = bus.mem_req_o && (gnt_at != 0) && (held + 1 == gnt_at);

    always_comb begin
        bus.mem_rdata_i = 32'h0;
        case (bus.mem_hb_o)
            2'b00:   bus.mem_rdata_i = {24'h0, sram[ra]};
            2'b01:   bus.mem_rdata_i = {16'h0, sram[ra + 13'd1], sram[ra]};
            default: bus.mem_rdata_i = {sram[ra + 13'd3], sram[ra + 13'd2],
                                        sram[ra + 13'd1], sram[ra]};
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 held <= 0;
        else if (bus.mem_req_o && !bus.mem_gnt_i)   held <= held + 1;
        else                                        held <= 0;
    end

    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < BYTES; i++) sram[i] <= pat(i);
            inited <= 1'b1;
        end else if (bus.mem_req_o && bus.mem_gnt_i && bus.mem_we_o) begin
            sram[ra] <= bus.mem_wdata_o[7:0];
            if (bus.mem_hb_o != 2'b00) sram[ra + 13'd1] <= bus.mem_wdata_o[15:8];
            if (bus.mem_hb_o == 2'b10) begin
                sram[ra + 13'd2] <= bus.mem_wdata_o[23:16];
                sram[ra + 13'd3] <= bus.mem_wdata_o[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [BYTES];
    int          exp_lat;
    logic        exp_err, exp_we;
    logic [2:0]  exp_cause;
    logic [31:0] exp_rdata, exp_off, exp_wdata;
    logic [1:0]  exp_hb;

    function automatic void predict(input logic we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    input int g);
        int     nb;
        bit     legal;
        int     c;
        longint a, v;
        a  = longint'(addr);
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal)                                         c = 6;
        else if (a % nb != 0)                               c = we ? 2 : 1;
        else if (a < longint'(BASE) || a >= longint'(BASE) + BYTES) c = we ? 4 : 3;
        else                                                c = 0;
        exp_we    = we;
        exp_off   = addr - BASE;
        exp_hb    = (nb == 1) ? 2'b00 : (nb == 2) ? 2'b01 : 2'b10;
        exp_wdata = wd;
        exp_rdata = 32'h0;
        if (c != 0) begin
            exp_lat = 1; exp_err = 1'b1; exp_cause = 3'(c);
        end else if (g == 0 || g > TMO) begin
            exp_lat = TMO + 1; exp_err = 1'b1; exp_cause = 3'd5;
        end else begin
            exp_lat = g + 1; exp_err = 1'b0; exp_cause = 3'd0;
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(exp_off) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v += longint'(ref_mem[int'(exp_off) + i]) << (8 * i);
                if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
                exp_rdata = 32'(v);
            end
        end
    endfunction

    // ---------------- compare process ----------------
    bit          cmp_en = 1'b0;
    bit          active = 1'b0;
    int          cyc;
    logic [31:0] last_rdata;
    logic [2:0]  last_cause;

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            if (active) begin
                cyc++;
                chk("ready_busy", bus.ready_o, 1'b0);
                if (cyc < exp_lat) begin
                    chk("req", bus.mem_req_o, 1'b1);
                    chk("ce", bus.mem_ce_o, 1'b1);
                    chk("mem_we", bus.mem_we_o, exp_we);
                    chk("mem_addr", bus.mem_addr_o, exp_off);
                    chk("mem_hb", bus.mem_hb_o, exp_hb);
                    if (exp_we) chk("mem_wdata", bus.mem_wdata_o, exp_wdata);
                    chk("done_early", bus.done_o, 1'b0);
                end else begin
                    chk("done", bus.done_o, 1'b1);
                    chk("req_at_done", bus.mem_req_o, 1'b0);
                    chk("err", bus.err_o, exp_err);
                    if (exp_err) chk("cause", bus.cause_o, exp_cause);
                    else         chk("rdata", bus.rdata_o, exp_rdata);
                    last_rdata = bus.rdata_o;
                    last_cause = bus.cause_o;
                    active = 1'b0;
                end
            end else begin
                chk("idle_ready", bus.ready_o, 1'b1);
                chk("idle_done", bus.done_o, 1'b0);
                chk("idle_req", bus.mem_req_o, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int g, input bit hold_v);
        @(negedge clk);
        predict(we, f3, addr, wd, g);
        gnt_at       = g;
        bus.valid_i  = 1'b1;
        bus.we_i     = we;
        bus.funct3_i = f3;
        bus.addr_i   = addr;
        bus.wdata_i  = wd;
        @(posedge clk);
        #1;
        cyc    = 0;
        active = 1'b1;
        if (hold_v) begin
            // junk request held during REQ must be ignored
            bus.we_i   = ~we;
            bus.addr_i = 32'h0000_2001;
        end else begin
            bus.valid_i = 1'b0;
        end
        for (int i = 0; i < 300 && active; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) bus.valid_i = 1'b0;
        end
        bus.valid_i = 1'b0;
        if (active) begin
            n_tests++; n_fail++;
            $display("FAIL op_no_done: got no done_o within bound, required done at cycle %0d", exp_lat);
            active = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < BYTES; i++) ref_mem[i] = pat(i);
        bus.valid_i = 1'b0; bus.we_i = 1'b0; bus.funct3_i = 3'b0;
        bus.addr_i = 32'h0; bus.wdata_i = 32'h0;
        #12;
        chk("rst_ready", bus.ready_o, 1'b1);
        chk("rst_done", bus.done_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_req", bus.mem_req_o, 1'b0);
        chk("rst_ce", bus.mem_ce_o, 1'b0);
        chk("rst_we", bus.mem_we_o, 1'b0);
        chk("rst_rdata", bus.rdata_o, 32'h0);
        chk("rst_cause", bus.cause_o, 3'h0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_hb", bus.mem_hb_o, 2'b00);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        do_op(1, 3'b010, 32'h2004, 32'hDEAD_BEEF, 3, 0);     // SW
        do_op(0, 3'b010, 32'h2004, 32'h0, 3, 1);              // LW, valid held during REQ
        chk("lat_lw_pin", exp_lat, 4);
        chk("lw_lit", last_rdata, 32'hDEAD_BEEF);
        do_op(1, 3'b000, 32'h2007, 32'h1234_5680, 3, 0);     // SB 0x80
        do_op(0, 3'b000, 32'h2007, 32'h0, 3, 0);              // LB
        chk("lb_lit", last_rdata, 32'hFFFF_FF80);
        do_op(0, 3'b100, 32'h2007, 32'h0, 3, 0);              // LBU
        chk("lbu_lit", last_rdata, 32'h0000_0080);
        do_op(0, 3'b010, 32'h2004, 32'h0, 3, 0);              // other bytes intact
        chk("lw_after_sb_lit", last_rdata, 32'h80AD_BEEF);
        do_op(0, 3'b001, 32'h2006, 32'h0, 3, 0);              // LH
        chk("lh_lit", last_rdata, 32'hFFFF_80AD);
        do_op(0, 3'b101, 32'h2006, 32'h0, 3, 0);              // LHU
        chk("lhu_lit", last_rdata, 32'h0000_80AD);
        do_op(1, 3'b001, 32'h2010, 32'hCAFE_7BCD, 3, 0);     // SH
        do_op(0, 3'b001, 32'h2010, 32'h0, 3, 0);
        chk("sh_lh_lit", last_rdata, 32'h0000_7BCD);

        do_op(0, 3'b001, 32'h2003, 32'h0, 3, 0);              // misaligned LH
        chk("lat_fault_pin", exp_lat, 1);
        chk("ld_misal_lit", last_cause, 3'd1);
        do_op(1, 3'b010, 32'h2002, 32'h1, 3, 0);
        chk("st_misal_lit", last_cause, 3'd2);
        do_op(0, 3'b010, 32'h1FFC, 32'h0, 3, 0);
        chk("ld_range_lit", last_cause, 3'd3);
        do_op(1, 3'b010, 32'h4000, 32'h1, 3, 0);
        chk("st_range_lit", last_cause, 3'd4);
        do_op(0, 3'b011, 32'h2000, 32'h0, 3, 0);
        chk("size_lit", last_cause, 3'd6);
        do_op(1, 3'b100, 32'h2000, 32'h0, 3, 0);              // SBU does not exist
        do_op(0, 3'b010, 32'h1FFD, 32'h0, 3, 0);              // misalign beats range
        do_op(0, 3'b011, 32'h1FFD, 32'h0, 3, 0);              // size beats both
        do_op(0, 3'b000, 32'h3FFF, 32'h0, 3, 0);              // last byte in window
        do_op(0, 3'b010, 32'h3FFC, 32'h0, 3, 0);

        do_op(0, 3'b010, 32'h2000, 32'h0, 0, 0);              // never granted
        chk("lat_tmo_pin", exp_lat, 16);
        chk("tmo_lit", last_cause, 3'd5);
        do_op(0, 3'b010, 32'h2004, 32'h0, 15, 0);             // grant on the last cycle
        chk("gnt15_lit", last_rdata, 32'h80AD_BEEF);
        do_op(1, 3'b010, 32'h2020, 32'h5555_AAAA, 16, 0);     // one cycle too late
        do_op(0, 3'b010, 32'h2020, 32'h0, 1, 0);              // timed-out store wrote nothing
        do_op(0, 3'b010, 32'h2018, 32'h0, 2, 0);

        // reset in the middle of REQ
        cmp_en = 1'b0;
        gnt_at = 0;
        @(negedge clk);
        bus.valid_i = 1'b1; bus.we_i = 1'b0; bus.funct3_i = 3'b010; bus.addr_i = 32'h2008;
        @(posedge clk); #1; bus.valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_req_pre", bus.mem_req_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", bus.mem_req_o, 1'b0);
        chk("rst_mid_ce", bus.mem_ce_o, 1'b0);
        chk("rst_mid_ready", bus.ready_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_done", bus.done_o, 1'b0);
            chk("post_rst_ready", bus.ready_o, 1'b1);
            chk("post_rst_req", bus.mem_req_o, 1'b0);
        end
        cmp_en = 1'b1;
        do_op(0, 3'b010, 32'h2004, 32'h0, 3, 0);
        chk("after_rst_lit", last_rdata, 32'h80AD_BEEF);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
